// File: rtl/pixel_fb_writer.sv
// ============================================================================
// pixel_fb_writer : plot FIFO -> linear frame-buffer writes, with clear sweep
// Revision 1.0
// ============================================================================
`default_nettype none

module pixel_fb_writer #(
  parameter int X_SCREENSIZE = 160,
  parameter int Y_SCREENSIZE = 120,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [7:0]            iX,
  input  logic [6:0]            iY,
  input  logic [2:0]            iColour,
  input  logic                  iPlot,
  input  logic                  iClear,
  input  logic [2:0]            iClearColour,
  input  logic                  iMemGnt,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [2:0]            oMemData,
  output logic                  oMemWe,
  output logic                  oBusy,
  output logic [3:0]            oLevel,
  output logic                  oOverflow,
  output logic [7:0]            oDropCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + 3;
  localparam logic [ADDR_WIDTH-1:0] c_x_size = ADDR_WIDTH'(X_SCREENSIZE);
  localparam logic [ADDR_WIDTH-1:0] c_last   = ADDR_WIDTH'(X_SCREENSIZE * Y_SCREENSIZE - 1);
  localparam logic [CNT_W-1:0]      c_full   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [2:0]            fill_colour_q, fill_colour_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]            mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];

  logic                  in_range;
  logic                  clear_acc;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  out_free;
  logic [PTR_W-1:0]      wr_idx;
  logic [ADDR_WIDTH-1:0] plot_addr;
  logic [ENT_W-1:0]      head;

  always_comb begin
    in_range  = (32'(iX) < X_SCREENSIZE) && (32'(iY) < Y_SCREENSIZE);
    clear_acc = iClear && (state_q != ST_CLEAR);
    // A flush on the same edge empties the FIFO, so the incoming plot always fits.
    fifo_full = (level_q == c_full) && !clear_acc;
    push      = iPlot && in_range && !fifo_full;
    out_free  = !mem_we_q || iMemGnt;
    pop       = (state_q == ST_DRAIN) && !clear_acc && out_free && (level_q != '0);
    wr_idx    = clear_acc ? '0 : wr_ptr_q;
    plot_addr = ADDR_WIDTH'(iY) * c_x_size + ADDR_WIDTH'(iX);
    head      = fifo_mem_q[rd_ptr_q];

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
    sweep_d       = sweep_q;
    fill_colour_d = fill_colour_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_we_d      = mem_we_q;

    if (clear_acc) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      overflow_d    = 1'b0;
      sweep_d       = '0;
      fill_colour_d = iClearColour;
    end

    if (iPlot && !in_range && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    if (iPlot && in_range && fifo_full) overflow_d = 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_d - 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_idx + 1'b1;
      level_d  = level_d + 1'b1;
    end

    if (out_free) begin
      mem_we_d = 1'b0;
      if (pop) begin
        {mem_addr_d, mem_data_d} = head;
        mem_we_d = 1'b1;
      end else if (state_q == ST_CLEAR) begin
        mem_addr_d = sweep_q;
        mem_data_d = fill_colour_q;
        mem_we_d   = 1'b1;
        sweep_d    = (sweep_q == c_last) ? '0 : sweep_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (clear_acc)               state_d = ST_CLEAR;
        else if (level_d != '0)      state_d = ST_DRAIN;
        else if (!mem_we_d)          state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (out_free && (sweep_q == c_last))
          state_d = (level_d != '0) ? ST_DRAIN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      sweep_q       <= '0;
      fill_colour_q <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      sweep_q       <= sweep_d;
      fill_colour_q <= fill_colour_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge iClock) begin
    if (push) fifo_mem_q[wr_idx] <= {plot_addr, iColour};
  end

  assign oMemAddr   = mem_addr_q;
  assign oMemData   = mem_data_q;
  assign oMemWe     = mem_we_q;
  assign oBusy      = (state_q == ST_CLEAR) || (level_q != '0) || mem_we_q;
  assign oLevel     = 4'(level_q);
  assign oOverflow  = overflow_q;
  assign oDropCount = drop_cnt_q;

endmodule

`default_nettype wire
